// File: rtl/register_pkg.sv
// Shared datapath definitions: default word width and the word type used by
// storage cells such as the general-purpose register.
package register_pkg;

    localparam int unsigned DATA_WIDTH = 32;

    typedef logic [DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/register.sv
// General-purpose data register with write enable and asynchronous
// active-high reset; Dout comes straight from the storage flops.
module register
    import register_pkg::*;
#(
    parameter int unsigned          WIDTH       = DATA_WIDTH,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WE,
    input  logic [WIDTH-1:0] Data,
    output logic [WIDTH-1:0] Dout
);

    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] dout_d;

    // An unknown WE falls through to the hold branch, so Data is never
    // loaded on an unresolved enable.
    always_comb begin
        dout_d = dout_q;
        if (WE) begin
            dout_d = Data;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dout_q <= RESET_VALUE;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign Dout = dout_q;

endmodule

// File: tb/tb_register.sv
// Self-checking bench for the register: directed boundary cases followed by
// randomized writes compared against a behavioural storage model.
module tb_register;

    logic        CLK;
    logic        RST;
    logic        WE;
    logic [31:0] Data;
    logic [31:0] Dout;
    logic [7:0]  dout_small;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_word;
    logic [7:0]  model_small;
    logic [31:0] exp_q[$];

    register u_dut (
        .CLK  (CLK),
        .RST  (RST),
        .WE   (WE),
        .Data (Data),
        .Dout (Dout)
    );

    register #(
        .WIDTH       (8),
        .RESET_VALUE (8'h5A)
    ) u_small (
        .CLK  (CLK),
        .RST  (RST),
        .WE   (WE),
        .Data (Data[7:0]),
        .Dout (dout_small)
    );

    // clock / reset block
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model of a storage word: reset forces the reset value, an enabled edge
    // stores the presented word, anything else leaves it alone.
    task automatic model_reset();
        model_word  = 32'h0;
        model_small = 8'h5A;
    endtask

    task automatic model_edge(input logic we, input logic [31:0] d);
        if (we === 1'b1) begin
            model_word  = d;
            model_small = d[7:0];
        end
    endtask

    // driver: present inputs on the falling edge, check just after the rising edge
    task automatic drive_cycle(input logic we, input logic [31:0] d, input string tag);
        @(negedge CLK);
        WE   = we;
        Data = d;
        model_edge(we, d);
        exp_q.push_back(model_word);
        @(posedge CLK);
        #1;
        check_eq(tag, Dout, exp_q.pop_front());
        check_eq({tag, "_w8"}, {24'h0, dout_small}, {24'h0, model_small});
    endtask

    initial begin
        RST  = 1'b1;
        WE   = 1'b1;
        Data = 32'h0000_00AA;
        model_reset();
        #1;
        check_eq("reset_async", Dout, 32'h0);
        check_eq("reset_w8", {24'h0, dout_small}, 32'h5A);
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            check_eq("reset_hold", Dout, 32'h0);
        end

        @(negedge CLK);
        RST = 1'b0;
        drive_cycle(1'b1, 32'h0000_0001, "write_first");
        check_eq("write_value", Dout, 32'h0000_0001);
        drive_cycle(1'b0, 32'h0000_0003, "hold_we0");
        check_eq("hold_value", Dout, 32'h0000_0001);

        #2;
        Data = 32'h1234_5678;
        #1;
        check_eq("hold_midcycle", Dout, 32'h0000_0001);
        Data = 32'h0000_0003;

        drive_cycle(1'b1, 32'h0000_0003, "reenable");
        check_eq("reenable_value", Dout, 32'h0000_0003);

        drive_cycle(1'b1, 32'hDEAD_BEEF, "load_deadbeef");
        @(negedge CLK);
        WE = 1'b0;
        #2;
        RST = 1'b1;
        model_reset();
        #1;
        check_eq("async_mid_cycle", Dout, 32'h0);
        check_eq("async_mid_w8", {24'h0, dout_small}, 32'h5A);
        RST = 1'b0;
        drive_cycle(1'b0, 32'hCAFE_F00D, "after_pulse_hold");

        drive_cycle(1'b1, 32'hFFFF_FFFF, "b2b_all_ones");
        drive_cycle(1'b1, 32'h8000_0000, "b2b_msb");
        drive_cycle(1'b1, 32'h0000_0000, "b2b_zero");
        drive_cycle(1'b1, 32'h7FFF_FFFF, "b2b_below_msb");

        // reset rising together with a write edge: reset must win
        @(negedge CLK);
        WE   = 1'b1;
        Data = 32'h1357_9BDF;
        @(posedge CLK);
        RST = 1'b1;
        model_reset();
        #1;
        check_eq("reset_vs_edge", Dout, 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        drive_cycle(1'b1, 32'h0F0F_0F0F, "first_edge_after_reset");

        @(negedge CLK);
        WE   = 1'bx;
        Data = 32'hBAD0_BAD0;
        @(posedge CLK);
        #1;
        check_eq("we_unknown_no_load", Dout, 32'h0F0F_0F0F);

        for (int i = 0; i < 200; i++) begin
            logic        we;
            logic [31:0] d;
            we = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: d = 32'hFFFF_FFFF;
                1: d = 32'h8000_0000 | 32'($urandom_range(0, 15));
                default: d = $urandom;
            endcase
            drive_cycle(we, d, "rand");
            if ($urandom_range(0, 3) == 0) begin
                #2;
                Data = $urandom;
                WE   = 1'($urandom_range(0, 1));
                #1;
                check_eq("rand_midcycle", Dout, model_word);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
